// File: rtl/action_dispatch.sv
// ---------------------------------------------------------------------------
// action_dispatch
//
// Pairs each action word from the rule lookup stage with the metadata word the
// parser issued for the same packet (strict FIFO order), decodes the action
// into a forwarding decision and hands it to the output scheduler over a
// valid/ready handshake. Forward/drop/CPU statistics and FIFO status are
// readable and clearable over the shared localbus.
//
// Build option:
//   DISPATCH_MISS_DROP_EN  when defined, action 16'h0000 (lookup miss) is
//                          turned into a drop with an empty port bitmap.
//
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   metadata_valid/metadata packet metadata from the parser
//   action_valid/action     action word: [15]=drop [14]=to_cpu [7:0]=ports
//   out_valid/out_ready     decision handshake to the output scheduler
//   out_metadata, out_port, out_drop, out_cpu   registered decision fields
//   localbus_cs_n, localbus_rd_wr, localbus_ale, localbus_data   bus inputs
//   localbus_ack_n, localbus_data_out                            bus outputs
//
// Localbus address map (addr[1:0], latched on ale with data[19]=1):
//   0 fwd_cnt, 1 drop_cnt, 2 cpu_cnt,
//   3 status {8'h0, act_level, meta_level, 6'b0, ovf_act, ovf_meta}
//   Any write clears the addressed item; write data is ignored.
// ---------------------------------------------------------------------------

// Single-clock FIFO used for both the metadata and the action queue.
// head shows the oldest entry whenever empty=0. A push while full is only
// accepted when a pop happens on the same edge; otherwise discard pulses.
module action_dispatch_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  head,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   level,
   output logic          discard
);

   localparam logic [AW:0] PTR_ONE = 1;

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         do_push;

   // Pointers carry one extra wrap bit, so the difference is the occupancy.
   assign level   = wr_ptr - rd_ptr;
   assign empty   = (level == '0);
   assign full    = level[AW];
   assign do_push = push & (~full | pop);
   assign discard = push & full & ~pop;
   assign head    = mem[rd_ptr[AW-1:0]];

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // NOTE: the storage array is deliberately not reset; emptiness is defined by
   // the pointers, and a resettable array would cost a reset net per bit.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

module action_dispatch #(
   parameter int MD_W  = 64,
   parameter int DEPTH = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            metadata_valid,
   input  logic [MD_W-1:0] metadata,
   input  logic            action_valid,
   input  logic [15:0]     action,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [MD_W-1:0] out_metadata,
   output logic [7:0]      out_port,
   output logic            out_drop,
   output logic            out_cpu,
   input  logic            localbus_cs_n,
   input  logic            localbus_rd_wr,
   input  logic            localbus_ale,
   input  logic [31:0]     localbus_data,
   output logic            localbus_ack_n,
   output logic [31:0]     localbus_data_out
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      idle,
      bus_wr,
      bus_rd,
      rd_wait,
      wait_back
   } bus_state_t;

   // ------------------------------------------------------------------------
   // Queues
   // ------------------------------------------------------------------------
   logic [MD_W-1:0] meta_head;
   logic            meta_empty;
   logic            meta_full;
   logic [AW:0]     meta_level;
   logic            meta_discard;

   logic [15:0]     act_head;
   logic            act_empty;
   logic            act_full;
   logic [AW:0]     act_level;
   logic            act_discard;

   logic            pop;

   // A decision can be loaded when both halves are present and the output
   // register is free or being emptied on this same edge.
   assign pop = ~meta_empty & ~act_empty & (~out_valid | out_ready);

   action_dispatch_fifo #(
      .W     (MD_W),
      .DEPTH (DEPTH)
   ) u_meta_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (metadata_valid),
      .push_data (metadata),
      .pop       (pop),
      .head      (meta_head),
      .empty     (meta_empty),
      .full      (meta_full),
      .level     (meta_level),
      .discard   (meta_discard)
   );

   action_dispatch_fifo #(
      .W     (16),
      .DEPTH (DEPTH)
   ) u_act_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (action_valid),
      .push_data (action),
      .pop       (pop),
      .head      (act_head),
      .empty     (act_empty),
      .full      (act_full),
      .level     (act_level),
      .discard   (act_discard)
   );

   // ------------------------------------------------------------------------
   // Action decode
   // ------------------------------------------------------------------------
   logic [7:0] dec_port;
   logic       dec_drop;
   logic       dec_cpu;

   // NOTE: every output of this block gets a default before any conditional
   // override, so no path leaves a value unassigned and no latch is inferred.
   always_comb begin
      dec_port = act_head[7:0];
      dec_drop = act_head[15];
      dec_cpu  = act_head[14];
`ifdef DISPATCH_MISS_DROP_EN
      if (act_head == 16'h0000) begin
         dec_drop = 1'b1;
         dec_port = 8'h00;
      end
`endif
   end

   // ------------------------------------------------------------------------
   // Output register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid    <= 1'b0;
         out_metadata <= '0;
         out_port     <= 8'h00;
         out_drop     <= 1'b0;
         out_cpu      <= 1'b0;
      end else if (pop) begin
         out_valid    <= 1'b1;
         out_metadata <= meta_head;
         out_port     <= dec_port;
         out_drop     <= dec_drop;
         out_cpu      <= dec_cpu;
      end else if (out_ready) begin
         out_valid    <= 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Localbus slave
   // ------------------------------------------------------------------------
   bus_state_t  bus_state;
   logic [1:0]  bus_addr;
   logic [31:0] rd_mux;
   logic        bus_clr;

   logic [31:0] fwd_cnt;
   logic [31:0] drop_cnt;
   logic [31:0] cpu_cnt;
   logic        ovf_meta;
   logic        ovf_act;

   // Write strobe: the clear lands on the same edge that drops ack_n.
   assign bus_clr = (bus_state == bus_wr) & ~localbus_cs_n;

   always_comb begin
      rd_mux = 32'h0;
      case (bus_addr)
         2'd0:    rd_mux = fwd_cnt;
         2'd1:    rd_mux = drop_cnt;
         2'd2:    rd_mux = cpu_cnt;
         default: rd_mux = {8'h00, 8'(act_level), 8'(meta_level),
                            6'b0, ovf_act, ovf_meta};
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus_state         <= idle;
         bus_addr          <= 2'd0;
         localbus_ack_n    <= 1'b1;
         localbus_data_out <= 32'h0;
      end else begin
         case (bus_state)
            idle: begin
               if (localbus_ale && localbus_data[19]) begin
                  bus_addr  <= localbus_data[1:0];
                  bus_state <= localbus_rd_wr ? bus_rd : bus_wr;
               end
            end
            bus_wr: begin
               if (!localbus_cs_n) begin
                  localbus_ack_n <= 1'b0;
                  bus_state      <= wait_back;
               end
            end
            bus_rd: begin
               if (!localbus_cs_n) bus_state <= rd_wait;
            end
            rd_wait: begin
               localbus_data_out <= rd_mux;
               localbus_ack_n    <= 1'b0;
               bus_state         <= wait_back;
            end
            wait_back: begin
               if (localbus_cs_n) begin
                  localbus_ack_n <= 1'b1;
                  bus_state      <= idle;
               end
            end
            default: bus_state <= idle;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Statistics and sticky overflow flags. A bus clear beats a coincident
   // increment or overflow event.
   // ------------------------------------------------------------------------
   logic handshake;
   assign handshake = out_valid & out_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fwd_cnt  <= 32'h0;
         drop_cnt <= 32'h0;
         cpu_cnt  <= 32'h0;
         ovf_meta <= 1'b0;
         ovf_act  <= 1'b0;
      end else begin
         if (bus_clr && bus_addr == 2'd0)       fwd_cnt  <= 32'h0;
         else if (handshake && !out_drop)       fwd_cnt  <= fwd_cnt + 32'd1;

         if (bus_clr && bus_addr == 2'd1)       drop_cnt <= 32'h0;
         else if (handshake && out_drop)        drop_cnt <= drop_cnt + 32'd1;

         if (bus_clr && bus_addr == 2'd2)       cpu_cnt  <= 32'h0;
         else if (handshake && out_cpu)         cpu_cnt  <= cpu_cnt + 32'd1;

         if (bus_clr && bus_addr == 2'd3) begin
            ovf_meta <= 1'b0;
            ovf_act  <= 1'b0;
         end else begin
            if (meta_discard) ovf_meta <= 1'b1;
            if (act_discard)  ovf_act  <= 1'b1;
         end
      end
   end

   // Reserved action bits, unused bus address bits and the FIFO full flags
   // (overflow is taken from the discard strobes) are intentionally ignored.
   logic unused_inputs;
   assign unused_inputs = ^{act_head[13:8], localbus_data[31:20],
                            localbus_data[18:2], meta_full, act_full};

endmodule

// File: tb/tb_action_dispatch.sv
`timescale 1ns/1ps
module tb_action_dispatch;

   localparam int MD_W  = 64;
   localparam int DEPTH = 8;

`ifdef DISPATCH_MISS_DROP_EN
   localparam bit MISS_DROP = 1'b1;
`else
   localparam bit MISS_DROP = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic            metadata_valid;
   logic [MD_W-1:0] metadata;
   logic            action_valid;
   logic [15:0]     action;
   logic            out_valid;
   logic            out_ready;
   logic [MD_W-1:0] out_metadata;
   logic [7:0]      out_port;
   logic            out_drop;
   logic            out_cpu;
   logic            localbus_cs_n;
   logic            localbus_rd_wr;
   logic            localbus_ale;
   logic [31:0]     localbus_data;
   logic            localbus_ack_n;
   logic [31:0]     localbus_data_out;

   action_dispatch #(.MD_W(MD_W), .DEPTH(DEPTH)) dut (
      .clk               (clk),
      .reset             (reset),
      .metadata_valid    (metadata_valid),
      .metadata          (metadata),
      .action_valid      (action_valid),
      .action            (action),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_metadata      (out_metadata),
      .out_port          (out_port),
      .out_drop          (out_drop),
      .out_cpu           (out_cpu),
      .localbus_cs_n     (localbus_cs_n),
      .localbus_rd_wr    (localbus_rd_wr),
      .localbus_ale      (localbus_ale),
      .localbus_data     (localbus_data),
      .localbus_ack_n    (localbus_ack_n),
      .localbus_data_out (localbus_data_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] md;
      logic [7:0]  port;
      logic        drop;
      logic        cpu;
   } dec_t;

   dec_t        exp_q[$];   // expected decisions, in order
   logic [63:0] meta_q[$];  // metadata pushed and not yet paired

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every accepted decision is compared against the scoreboard.
   initial begin
      dec_t e;
      forever begin
         @(negedge clk);
         if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL spurious_decision: got md=%0h, expected no decision", out_metadata);
            end else begin
               e = exp_q.pop_front();
               check("dec_md",   out_metadata, e.md);
               check("dec_port", 64'(out_port), 64'(e.port));
               check("dec_drop", 64'(out_drop), 64'(e.drop));
               check("dec_cpu",  64'(out_cpu),  64'(e.cpu));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // All stimulus tasks start and end just after a rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_meta(input logic [63:0] md, input bit kept);
      metadata_valid = 1'b1;
      metadata       = md;
      if (kept) meta_q.push_back(md);
      tick();
      metadata_valid = 1'b0;
   endtask

   task automatic push_act(input logic [15:0] a, input logic [7:0] port,
                           input logic drop, input logic cpu);
      dec_t e;
      action_valid = 1'b1;
      action       = a;
      e.md   = (meta_q.size() > 0) ? meta_q.pop_front() : 64'hX;
      e.port = port;
      e.drop = drop;
      e.cpu  = cpu;
      exp_q.push_back(e);
      tick();
      action_valid = 1'b0;
   endtask

   task automatic push_both(input logic [63:0] md, input logic [15:0] a,
                            input logic [7:0] port, input logic drop, input logic cpu);
      dec_t e;
      metadata_valid = 1'b1;
      metadata       = md;
      action_valid   = 1'b1;
      action         = a;
      e.md = md; e.port = port; e.drop = drop; e.cpu = cpu;
      exp_q.push_back(e);
      tick();
      metadata_valid = 1'b0;
      action_valid   = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check(name, 64'(exp_q.size()), 64'd0);
      tick();
   endtask

   task automatic wait_ack(input logic val, input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (localbus_ack_n !== val && n < 20);
      check(name, 64'(localbus_ack_n), 64'(val));
   endtask

   task automatic bus_addr_phase(input logic [1:0] addr, input logic rd);
      localbus_ale   = 1'b1;
      localbus_rd_wr = rd;
      localbus_data  = {12'h000, 1'b1, 17'h0, addr};
      tick();
      localbus_ale   = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
      bus_addr_phase(addr, 1'b1);
      localbus_cs_n = 1'b0;
      wait_ack(1'b0, "rd_ack_low");
      data = localbus_data_out;
      tick();
      localbus_cs_n = 1'b1;
      wait_ack(1'b1, "rd_ack_high");
      tick();
   endtask

   task automatic bus_write(input logic [1:0] addr);
      bus_addr_phase(addr, 1'b0);
      localbus_data = 32'h1234_5678;  // ignored by the design
      localbus_cs_n = 1'b0;
      wait_ack(1'b0, "wr_ack_low");
      tick();
      localbus_cs_n = 1'b1;
      wait_ack(1'b1, "wr_ack_high");
      tick();
   endtask

   task automatic read_check(input logic [1:0] addr, input logic [31:0] exp, input string name);
      logic [31:0] d;
      bus_read(addr, d);
      check(name, 64'(d), 64'(exp));
   endtask

   initial begin
      reset          = 1'b0;
      metadata_valid = 1'b0;
      metadata       = '0;
      action_valid   = 1'b0;
      action         = 16'h0;
      out_ready      = 1'b1;
      localbus_cs_n  = 1'b1;
      localbus_rd_wr = 1'b0;
      localbus_ale   = 1'b0;
      localbus_data  = 32'h0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_md",    out_metadata, 64'd0);
      check("rst_out_port",  64'(out_port), 64'd0);
      check("rst_out_drop",  64'(out_drop), 64'd0);
      check("rst_out_cpu",   64'(out_cpu), 64'd0);
      check("rst_ack_n",     64'(localbus_ack_n), 64'd1);
      check("rst_data_out",  64'(localbus_data_out), 64'd0);
      tick();
      reset = 1'b1;
      tick();

      // Test 1: metadata, action two cycles later, ready high
      push_meta(64'hA, 1'b1);
      tick();
      push_act(16'h0003, 8'h03, 1'b0, 1'b0);
      @(negedge clk);
      check("t1_valid_before_pop", 64'(out_valid), 64'd0);
      @(negedge clk);
      check("t1_valid_after_pop", 64'(out_valid), 64'd1);
      tick();
      read_check(2'd0, 32'd1, "t1_fwd_cnt");
      read_check(2'd1, 32'd0, "t1_drop_cnt");

      // Test 2: four decisions held behind a 10-cycle stall
      bus_write(2'd0);
      bus_write(2'd1);
      bus_write(2'd2);
      out_ready = 1'b0;
      push_meta(64'h1111, 1'b1);
      push_meta(64'h2222, 1'b1);
      push_meta(64'h3333, 1'b1);
      push_meta(64'h4444, 1'b1);
      push_act(16'h8000, 8'h00, 1'b1, 1'b0);
      push_act(16'h4001, 8'h01, 1'b0, 1'b1);
      push_act(16'h0002, 8'h02, 1'b0, 1'b0);
      push_act(16'hC000, 8'h00, 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t2_stall_md", out_metadata, 64'h1111);
      end
      check("t2_stall_valid", 64'(out_valid), 64'd1);
      check("t2_stall_drop",  64'(out_drop), 64'd1);
      tick();
      out_ready = 1'b1;
      drain("t2_drain");
      read_check(2'd0, 32'd2, "t2_fwd_cnt");
      read_check(2'd1, 32'd2, "t2_drop_cnt");
      read_check(2'd2, 32'd2, "t2_cpu_cnt");

      // Test 3: metadata FIFO overflow, status, flag clear
      for (int i = 1; i <= 9; i++) push_meta(64'(i) + 64'h3000, (i <= 8));
      read_check(2'd3, 32'h0000_0801, "t3_status_ovf");
      bus_write(2'd3);
      read_check(2'd3, 32'h0000_0800, "t3_status_clr");
      for (int i = 0; i < 8; i++) push_act(16'h0010, 8'h10, 1'b0, 1'b0);
      drain("t3_drain");
      read_check(2'd3, 32'h0000_0000, "t3_status_empty");

      // Test 4: five forwards, counter read, clear coincident with handshake
      bus_write(2'd0);
      for (int i = 0; i < 5; i++) push_both(64'h50 + 64'(i), 16'h0001 << i, 8'h01 << i, 1'b0, 1'b0);
      drain("t4_drain");
      read_check(2'd0, 32'd5, "t4_fwd_cnt");
      out_ready = 1'b0;
      push_both(64'h60, 16'h0080, 8'h80, 1'b0, 1'b0);
      tick();
      tick();
      @(negedge clk);
      check("t4_pending_valid", 64'(out_valid), 64'd1);
      tick();
      bus_addr_phase(2'd0, 1'b0);
      localbus_cs_n = 1'b0;   // clear edge and handshake edge coincide
      out_ready     = 1'b1;
      wait_ack(1'b0, "t4_wr_ack_low");
      tick();
      localbus_cs_n = 1'b1;
      wait_ack(1'b1, "t4_wr_ack_high");
      tick();
      drain("t4_coinc_drain");
      read_check(2'd0, 32'd0, "t4_fwd_clear_wins");

      // Test 5: lookup miss
      bus_write(2'd0);
      bus_write(2'd1);
      push_both(64'h70, 16'h0000, 8'h00, MISS_DROP, 1'b0);
      drain("t5_drain");
      read_check(2'd0, MISS_DROP ? 32'd0 : 32'd1, "t5_fwd_cnt");
      read_check(2'd1, MISS_DROP ? 32'd1 : 32'd0, "t5_drop_cnt");

      // Test 6: reset with one decision presented and three queued
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_both(64'h80 + 64'(i), 16'h0001, 8'h01, 1'b0, 1'b0);
      tick();
      tick();
      @(negedge clk);
      check("t6_valid_before_rst", 64'(out_valid), 64'd1);
      tick();
      reset = 1'b0;
      #1;
      check("t6_valid_in_rst", 64'(out_valid), 64'd0);
      check("t6_md_in_rst",    out_metadata, 64'd0);
      exp_q.delete();
      meta_q.delete();
      tick();
      reset     = 1'b1;
      out_ready = 1'b1;
      tick();
      tick();
      @(negedge clk);
      check("t6_valid_after_rst", 64'(out_valid), 64'd0);
      tick();
      read_check(2'd3, 32'h0000_0000, "t6_status_levels");
      read_check(2'd0, 32'd0, "t6_fwd_after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/action_dispatch.md
Name: action_dispatch

Overview:
- Downstream neighbour of the rule lookup stage. Consumes the per-packet action word (action_valid/action[15:0], produced 2 cycles after the countid lookup).
- Pairs each action, in order, with the packet metadata the parser issued alongside the lookup. Emits a decoded forwarding decision to the output scheduler over a valid/ready handshake.
- Keeps forward/drop/CPU statistics, readable and clearable over the shared localbus.

Parameters:
- MD_W, 64, width of packet metadata word.
- DEPTH, 8, entries in each of the metadata FIFO and the action FIFO (power of 2, min 2).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- metadata_valid  in  1  metadata word present this cycle
- metadata  in  MD_W  packet metadata from parser
- action_valid  in  1  action word present this cycle, from rule lookup
- action  in  16  action word: [15]=drop, [14]=to_cpu, [7:0]=output port bitmap, others reserved
- out_valid  out  1  decision valid
- out_ready  in  1  downstream accepts decision
- out_metadata  out  MD_W  paired metadata
- out_port  out  8  output port bitmap (action[7:0])
- out_drop  out  1  drop decision
- out_cpu  out  1  copy-to-CPU decision
- localbus_cs_n, localbus_rd_wr, localbus_ale  in  1  localbus strobes
- localbus_data  in  32  localbus address/data
- localbus_ack_n  out  1  localbus acknowledge, active-low
- localbus_data_out  out  32  localbus read data

Behaviour:
- Reset (async, active-low): both FIFOs empty; all counters and flags 0; out_valid=0, out_metadata=0, out_port=0, out_drop=0, out_cpu=0; localbus_ack_n=1, localbus_data_out=0; bus FSM in idle. Reset mid-transaction aborts it; the in-flight packet is lost.
- Metadata FIFO push on metadata_valid; action FIFO push on action_valid. Push into a full FIFO discards the word and sets sticky flag ovf_meta or ovf_act respectively.
- Pop condition: both FIFOs non-empty AND (out_valid=0 OR out_ready=1). On pop, one word is taken from each FIFO, and the output registers load on the same clock edge, so out_valid is high the cycle after the pop condition holds.
- out_valid holds, with outputs stable, until out_ready=1. If out_ready=1 and no pop occurs, out_valid clears next cycle. Throughput: 1 decision/cycle.
- An action arriving with the metadata FIFO empty stays queued; pairing is strictly FIFO order. No timeout.
- Simultaneous push and pop on the same FIFO is allowed at any occupancy except a push when full with no pop, which is discarded.
- Statistics are counted at handshake (out_valid & out_ready), 32-bit, wrap at 2^32:
  - fwd_cnt increments when out_drop=0.
  - drop_cnt increments when out_drop=1.
  - cpu_cnt increments when out_cpu=1, independent of drop.
- Bus FSM states: idle, bus_wr, bus_rd, rd_wait, wait_back.
  - idle: on localbus_ale=1 and localbus_data[19]=1, latch address; go to bus_rd if localbus_rd_wr=1, else bus_wr.
  - bus_wr: on cs_n=0, clear the selected item, drive ack_n=0, go to wait_back.
  - bus_rd: on cs_n=0, go to rd_wait.
  - rd_wait: load localbus_data_out, drive ack_n=0, go to wait_back.
  - wait_back: on cs_n=1, drive ack_n=1, go to idle.
- Address map (addr[1:0]):
  - 0 = fwd_cnt, 1 = drop_cnt, 2 = cpu_cnt.
  - 3 = status {30'b0, ovf_act, ovf_meta}, plus meta FIFO level in [15:8] and action FIFO level in [23:16].
  - Write to any address clears it: counter cleared, or status flags cleared; write data is ignored.
- Clear and increment in the same cycle: clear wins, counter reads 0.

Optional Feature:
- DISPATCH_MISS_DROP_EN
  - Defined: action==16'h0000 (lookup miss) forces out_drop=1 and out_port=0, and the packet counts as drop.
  - Undefined: action 0 is decoded literally (forward, empty bitmap) and counts as fwd.

Test Plan:
- meta M0=64'hA, then action 16'h0003 two cycles later, out_ready=1 -> out_valid one cycle after action arrives, out_metadata=64'hA, out_port=8'h03, out_drop=0; fwd_cnt=1.
- 4 metas back-to-back, actions 16'h8000/16'h4001/16'h0002/16'hC000, out_ready=0 for 10 cycles then 1 -> outputs hold first decision while stalled, then 4 decisions in order; drop_cnt=2, cpu_cnt=2, fwd_cnt=2.
- 9 metadata pushes with no actions (DEPTH=8) -> status read returns bit0=1 and meta level=8; a write to addr 3 clears the flag.
- Localbus read of addr 0 after 5 forwards -> ack_n low, localbus_data_out=32'd5; deassert cs_n -> ack_n=1. A write to addr 0 coincident with a handshake -> subsequent read returns 0.
- Action 16'h0000 -> with DISPATCH_MISS_DROP_EN: out_drop=1, drop_cnt+1; without it: out_drop=0, out_port=0, fwd_cnt+1.
- Assert reset while 3 entries are queued and out_valid=1 -> out_valid=0 immediately; after release, FIFO levels read 0.
